// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared port addresses and status bit positions for io_port_bank
package io_pkg;

    localparam int IO_DATA_W = 16;

    localparam logic [3:0] IO_GPIO_OUT = 4'd0;
    localparam logic [3:0] IO_GPIO_IN  = 4'd1;
    localparam logic [3:0] IO_TX       = 4'd2;
    localparam logic [3:0] IO_RX       = 4'd3;
    localparam logic [3:0] IO_STATUS   = 4'd4;
    localparam logic [3:0] IO_SCRATCH  = 4'd5;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_FULL   = 2;
    localparam int ST_RX_EMPTY  = 3;
    localparam int ST_TX_CNT    = 4;
    localparam int ST_RX_CNT    = 8;
    localparam int ST_TX_DROP   = 12;
    localparam int ST_RX_UNDER  = 13;
    localparam int ST_RX_BUSY   = 14;

endpackage

// File: rtl/io_fifo.sv
// rtl/io_fifo.sv - registered-pointer FIFO with occupancy count
module io_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop & ~empty;
    // a pop on the same edge frees the slot, so a full FIFO can still take a push
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/io_port_bank.sv
// rtl/io_port_bank.sv - IO responder: GPIO, TX/RX FIFOs, status and scratch on d_bus
module io_port_bank
    import io_pkg::*;
#(
    parameter int DATA_W     = IO_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        io_addr,
    input  logic              io_addr_read,
    input  logic              io_read,
    input  logic              io_push,
    input  logic              io_write,
    inout  wire  [DATA_W-1:0] d_bus,
    output logic [DATA_W-1:0] gpio_out,
    input  logic [DATA_W-1:0] gpio_in,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
);

    logic [DATA_W-1:0] gpio_meta;
    logic [DATA_W-1:0] gpio_sync;
    logic [DATA_W-1:0] scratch;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] port_val;
    logic [DATA_W-1:0] status;
    logic              tx_drop;
    logic              rx_under;
    logic              rx_busy;

    logic              rd;
    logic              wr;
    logic              tx_push;
    logic              tx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic [CNT_W-1:0]  tx_count;
    logic              rx_push;
    logic              rx_pop;
    logic [DATA_W-1:0] rx_head;
    logic              rx_full;
    logic              rx_empty;
    logic [CNT_W-1:0]  rx_count;
    logic              stat_clr;
    logic              tx_drop_set;
    logic              rx_under_set;
    logic              rx_busy_set;

    assign rd       = io_addr_read & io_read;
    assign wr       = io_addr_read & io_write;
    assign tx_push  = wr & (io_addr == IO_TX);
    assign tx_pop   = tx_valid & tx_ready;
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = rd & (io_addr == IO_RX);
    assign stat_clr = rd & (io_addr == IO_STATUS);

    assign tx_drop_set  = tx_push & tx_full & ~tx_pop;
    assign rx_under_set = rx_pop & rx_empty;
    assign rx_busy_set  = rx_valid & rx_full;

    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;

    // drive is gated by rst_n so the bus floats the instant reset asserts
    assign d_bus = (io_addr_read & io_push & rst_n) ? hold_q : {DATA_W{1'bz}};

    io_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push),
        .push_data (d_bus),
        .pop       (tx_pop),
        .head      (tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    io_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    always_comb begin
        status                          = '0;
        status[ST_TX_FULL]              = tx_full;
        status[ST_TX_EMPTY]             = tx_empty;
        status[ST_RX_FULL]              = rx_full;
        status[ST_RX_EMPTY]             = rx_empty;
        status[ST_TX_CNT +: CNT_W]      = tx_count;
        status[ST_RX_CNT +: CNT_W]      = rx_count;
        status[ST_TX_DROP]              = tx_drop;
        status[ST_RX_UNDER]             = rx_under;
        status[ST_RX_BUSY]              = rx_busy;
    end

    always_comb begin
        port_val = '0;
        case (io_addr)
            IO_GPIO_OUT: port_val = gpio_out;
            IO_GPIO_IN:  port_val = gpio_sync;
            IO_RX:       port_val = rx_empty ? '0 : rx_head;
            IO_STATUS:   port_val = status;
            IO_SCRATCH:  port_val = scratch;
            default:     port_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_meta <= '0;
            gpio_sync <= '0;
            gpio_out  <= '0;
            scratch   <= '0;
            hold_q    <= '0;
            tx_drop   <= 1'b0;
            rx_under  <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            gpio_meta <= gpio_in;
            gpio_sync <= gpio_meta;
            if (rd) hold_q <= port_val;
            if (wr && io_addr == IO_GPIO_OUT) gpio_out <= d_bus;
            if (wr && io_addr == IO_SCRATCH)  scratch  <= d_bus;
            // a flag raised on the clearing edge is kept
            tx_drop  <= (tx_drop  & ~stat_clr) | tx_drop_set;
            rx_under <= (rx_under & ~stat_clr) | rx_under_set;
            rx_busy  <= (rx_busy  & ~stat_clr) | rx_busy_set;
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
// tb/tb_io_port_bank.sv - scoreboard bench for io_port_bank
module tb_io_port_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  io_addr;
    logic        io_addr_read;
    logic        io_read;
    logic        io_push;
    logic        io_write;
    wire  [15:0] d_bus;
    logic [15:0] gpio_out;
    logic [15:0] gpio_in;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;

    logic        tb_oe;
    logic [15:0] tb_drv;

    int tests = 0;
    int fails = 0;
    logic [15:0] bus_q[$];
    logic [15:0] tx_q[$];

    always #5 clk = ~clk;

    // undriven bus reads back as all ones
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (d_bus[i]);
    end
    assign d_bus = tb_oe ? tb_drv : 16'hzzzz;

    io_port_bank dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .io_addr      (io_addr),
        .io_addr_read (io_addr_read),
        .io_read      (io_read),
        .io_push      (io_push),
        .io_write     (io_write),
        .d_bus        (d_bus),
        .gpio_out     (gpio_out),
        .gpio_in      (gpio_in),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (io_addr_read && io_push && rst_n) begin
            if (bus_q.size() == 0) check("bus_unexpected_push", d_bus, 16'hFFFF ^ d_bus);
            else check("bus_push", d_bus, bus_q.pop_front());
        end else if (!tb_oe) begin
            check("bus_float", d_bus, 16'hFFFF);
        end
        if (tx_valid && tx_ready && rst_n) begin
            if (tx_q.size() == 0) check("tx_unexpected", tx_data, ~tx_data);
            else check("tx_drain", tx_data, tx_q.pop_front());
        end
    end

    task automatic io_rd(input logic [3:0] addr, input logic [15:0] exp);
        @(posedge clk); #1;
        io_addr_read = 1'b1; io_addr = addr; io_read = 1'b1;
        @(posedge clk); #1;
        io_read = 1'b0; io_push = 1'b1;
        bus_q.push_back(exp);
        @(posedge clk); #1;
        io_push = 1'b0; io_addr_read = 1'b0;
    endtask

    task automatic io_wr(input logic [3:0] addr, input logic [15:0] data, input logic also_read);
        @(posedge clk); #1;
        io_addr_read = 1'b1; io_addr = addr; io_write = 1'b1; io_read = also_read;
        tb_oe = 1'b1; tb_drv = data;
        @(posedge clk); #1;
        io_write = 1'b0; io_read = 1'b0; tb_oe = 1'b0;
        if (!also_read) io_addr_read = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; io_addr = 4'd0; io_addr_read = 1'b1; io_read = 1'b0; io_push = 1'b1;
        io_write = 1'b0; gpio_in = '0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        tb_oe = 1'b0; tb_drv = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_bus_float", d_bus, 16'hFFFF);
        check("reset_gpio_out", gpio_out, 16'h0000);
        check("reset_tx_valid", {15'd0, tx_valid}, 16'h0000);
        io_push = 1'b0; io_addr_read = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_rx_ready", {15'd0, rx_ready}, 16'h0001);
        io_rd(4'd4, 16'h000A);

        io_wr(4'd0, 16'hBEEF, 1'b0);
        check("gpio_out_write", gpio_out, 16'hBEEF);
        io_rd(4'd0, 16'hBEEF);

        // read and write together: hold_q takes the pre-write scratch value
        io_wr(4'd5, 16'h1234, 1'b1);
        io_push = 1'b1;
        bus_q.push_back(16'h0000);
        @(posedge clk); #1;
        io_push = 1'b0; io_addr_read = 1'b0;
        io_rd(4'd5, 16'h1234);

        tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) io_wr(4'd2, 16'(i), 1'b0);
        io_rd(4'd4, 16'h1049);
        io_rd(4'd4, 16'h0049);
        io_rd(4'd2, 16'h0000);
        for (int i = 1; i <= 4; i++) tx_q.push_back(16'(i));
        @(posedge clk); #1;
        tx_ready = 1'b1;
        for (int n = 0; n < 20 && tx_valid; n++) @(posedge clk);
        #1;
        check("tx_drained", {15'd0, tx_valid}, 16'h0000);
        check("tx_q_consumed", 16'(tx_q.size()), 16'h0000);
        tx_ready = 1'b0;

        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = 16'h1111;
        @(posedge clk); #1;
        rx_data = 16'h2222;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        io_rd(4'd3, 16'h1111);
        io_rd(4'd3, 16'h2222);
        io_rd(4'd3, 16'h0000);
        io_rd(4'd4, 16'h200A);

        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            rx_valid = 1'b1; rx_data = 16'hA000 + 16'(i);
        end
        @(posedge clk); #1;
        rx_data = 16'hA004;
        check("rx_full_not_ready", {15'd0, rx_ready}, 16'h0000);
        @(posedge clk); #1;
        io_addr_read = 1'b1; io_addr = 4'd3; io_read = 1'b1;
        @(posedge clk); #1;
        check("rx_ready_after_pop", {15'd0, rx_ready}, 16'h0001);
        io_read = 1'b0; io_push = 1'b1;
        bus_q.push_back(16'hA000);
        @(posedge clk); #1;
        io_push = 1'b0; io_addr_read = 1'b0; rx_valid = 1'b0;
        io_rd(4'd4, 16'h4406);
        io_rd(4'd4, 16'h0406);
        for (int i = 1; i <= 4; i++) io_rd(4'd3, 16'hA000 + 16'(i));
        io_rd(4'd4, 16'h000A);

        gpio_in = 16'h00FF;
        repeat (2) @(posedge clk);
        io_rd(4'd1, 16'h00FF);
        io_rd(4'd9, 16'h0000);

        // reset in the push phase with a non-empty TX FIFO
        io_wr(4'd2, 16'h0055, 1'b0);
        @(posedge clk); #1;
        io_addr_read = 1'b1; io_addr = 4'd0; io_read = 1'b1;
        @(posedge clk); #1;
        io_read = 1'b0; io_push = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("midpush_reset_float", d_bus, 16'hFFFF);
        check("midpush_reset_gpio", gpio_out, 16'h0000);
        check("midpush_reset_tx_valid", {15'd0, tx_valid}, 16'h0000);
        @(posedge clk); #1;
        io_push = 1'b0; io_addr_read = 1'b0; rst_n = 1'b1;
        io_rd(4'd4, 16'h000A);

        repeat (2) @(posedge clk);
        check("bus_q_consumed", 16'(bus_q.size()), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
